// File: rtl/iter_mul_unit.sv
// iter_mul_unit: iterative shift-add multiplier with register-file write-back; ITER_MUL_EARLY_TERM_EN exits once the multiplier is exhausted
module iter_mul_unit #(
    parameter int N  = 64,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   dest,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [4:0]   wa,
    output logic         we
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [N-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, result_q, result_d;
    logic [N-1:0] acc_add, mplier_sh;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0] wa_q, wa_d;
    logic done_q, done_d, we_q, we_d, last;
    assign acc_add = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mplier_sh = mplier_q >> 1;
`ifdef ITER_MUL_EARLY_TERM_EN
    assign last = (cnt_q == CW'(N - 1)) || (mplier_sh == '0);
`else
    assign last = cnt_q == CW'(N - 1);
`endif
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wa_d     = wa_q;
        result_d = result_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        if (state_q == IDLE && start) begin
            mcand_d  = a;
            mplier_d = b;
            wa_d     = dest;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = RUN;
        end else if (state_q == RUN) begin
            acc_d    = acc_add;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_sh;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                state_d  = DONE;
                result_d = acc_add;
                done_d   = 1'b1;
                we_d     = wa_q != 5'd31;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            wa_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wa_q     <= wa_d;
            result_q <= result_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end
    assign busy   = state_q != IDLE;
    assign done   = done_q;
    assign we     = we_q;
    assign wa     = wa_q;
    assign result = result_q;
endmodule

// File: tb/tb_iter_mul_unit.sv
// tb_iter_mul_unit: directed checks of iter_mul_unit for N=64
module tb_iter_mul_unit;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [4:0] dest = '0;
    logic busy, done, we;
    logic [63:0] result;
    logic [4:0] wa;
    int tests = 0, fails = 0;
`ifdef ITER_MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif
    localparam int MID = ET ? 1 : 10;

    iter_mul_unit #(.N(64)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .dest(dest),
        .busy(busy), .done(done), .result(result), .wa(wa), .we(we)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pulses start, then follows the unit through RUN and DONE; runs counts busy non-done cycles.
    task automatic run_mul(input logic [63:0] ia, input logic [63:0] ib, input logic [4:0] id,
                           output int runs, output int ndone, output logic [63:0] r,
                           output logic [4:0] w, output logic e);
        a = ia; b = ib; dest = id; start = 1'b1;
        step();
        start = 1'b0;
        runs = 0; ndone = 0; r = 'x; w = 'x; e = 1'bx;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            if (done) begin
                ndone++; r = result; w = wa; e = we;
            end else runs++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        step(); step();
        chk("reset_hold", {busy, done, we, wa, result}, '0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_idle", {busy, done, we, wa, result}, '0);
        end
    endtask

    task automatic test_basic();
        int runs, nd; logic [63:0] r; logic [4:0] w; logic e;
        run_mul(64'd3, 64'd5, 5'd9, runs, nd, r, w, e);
        chk("basic_runs", runs, ET ? 3 : 64);
        chk("basic_ndone", nd, 1);
        chk("basic_result", r, 64'd15);
        chk("basic_wa", w, 9);
        chk("basic_we", e, 1);
    endtask

    task automatic test_overflow();
        int runs, nd; logic [63:0] r; logic [4:0] w; logic e;
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, runs, nd, r, w, e);
        chk("ovf_runs", runs, ET ? 2 : 64);
        chk("ovf_result", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ovf_wa", w, 4);
        chk("ovf_we", e, 1);
    endtask

    task automatic test_zero_and_signed();
        int runs, nd; logic [63:0] r; logic [4:0] w; logic e;
        run_mul(64'd0, 64'd12345, 5'd1, runs, nd, r, w, e);
        chk("a0_runs", runs, ET ? 14 : 64);
        chk("a0_result", r, 64'd0);
        run_mul(64'd77, 64'd0, 5'd1, runs, nd, r, w, e);
        chk("b0_runs", runs, ET ? 1 : 64);
        chk("b0_result", r, 64'd0);
        chk("b0_ndone", nd, 1);
        run_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd12, runs, nd, r, w, e);
        chk("signed_runs", runs, ET ? 3 : 64);
        chk("signed_result", r, 64'hFFFF_FFFF_FFFF_FFEB);
    endtask

    task automatic test_start_while_busy();
        int runs = 0, nd = 0; logic [63:0] r = 'x; logic [4:0] w = 'x;
        a = 64'd7; b = 64'd6; dest = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            if (done) begin nd++; r = result; w = wa; end else runs++;
            if (i == MID) begin a = 64'd1; b = 64'd1; dest = 5'd3; start = 1'b1; end
            else start = 1'b0;
            step();
        end
        start = 1'b0;
        chk("busy_runs", runs, ET ? 3 : 64);
        chk("busy_ndone", nd, 1);
        chk("busy_result", r, 64'd42);
        chk("busy_wa", w, 2);
        step();
        chk("busy_no_restart", busy, 0);
    endtask

    task automatic test_dest31();
        int runs, nd; logic [63:0] r; logic [4:0] w; logic e;
        run_mul(64'd10, 64'd10, 5'd31, runs, nd, r, w, e);
        chk("r31_ndone", nd, 1);
        chk("r31_result", r, 64'd100);
        chk("r31_wa", w, 31);
        chk("r31_we", e, 0);
    endtask

    task automatic test_back_to_back();
        int nd = 0; logic [63:0] r = 'x;
        a = 64'd4; b = 64'd5; dest = 5'd7; start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_accepted", busy, 1);
        chk("b2b_wa_latched", wa, 7);
        chk("b2b_result_held", result, 64'd100);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            if (done) begin nd++; r = result; end
            step();
        end
        chk("b2b_ndone", nd, 1);
        chk("b2b_result", r, 64'd20);
        step(); step();
        chk("b2b_result_after", result, 64'd20);
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0, busy_seen = 0;
        a = 64'd9; b = 64'd9; dest = 5'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < MID; i++) step();
        chk("mid_still_run", {busy, done}, 2'b10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_state", {busy, done, we, wa, result}, '0);
        for (int i = 0; i < 70; i++) begin
            step();
            if (done || we) pulses++;
            if (busy) busy_seen++;
        end
        chk("mid_no_pulse", pulses, 0);
        chk("mid_no_busy", busy_seen, 0);
        chk("mid_result_zero", result, 64'd0);
        reset = 1'b1; start = 1'b1; a = 64'd3; b = 64'd3; dest = 5'd8;
        step();
        reset = 1'b0; start = 1'b0;
        chk("rst_start_same", {busy, wa}, '0);
        step();
        chk("rst_start_after", busy, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_and_signed();
        test_start_while_busy();
        test_dest31();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iter_mul_unit.md
Name: iter_mul_unit

Overview:
- Iterative shift-add multiplier in the execute stage, directly downstream of the register file.
- Takes the two register read values and a destination register index.
- Computes the low N bits of the unsigned product over multiple cycles.
- Presents the result as a one-cycle write-back (value, address, write enable) that drives the register file write port.

Parameters:
N, 64, operand/result width in bits (must be ≥ 2)
CW, $clog2(N), iteration counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
a  input  N  multiplicand (register read port 1 value)
b  input  N  multiplier (register read port 2 value)
dest  input  5  destination register index
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
result  output  N  product, low N bits
wa  output  5  write-back register index (latched dest)
we  output  1  write-back enable, done && (wa != 31)

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - Port names are clk and reset.
- Reset values:
  - state = IDLE; busy = 0; done = 0; we = 0; result = 0; wa = 0.
  - Internal multiplicand, multiplier, accumulator and counter all = 0.
- IDLE:
  - With start = 1: latch mcand = a, mplier = b, wa = dest; acc = 0; cnt = 0; next state RUN.
  - With start = 0: stay in IDLE.
- RUN, one iteration per cycle:
  - If mplier[0], then acc = acc + mcand; the carry out of bit N-1 is discarded (mod 2^N).
  - mcand <<= 1 (zero fill); mplier >>= 1 (zero fill); cnt++.
  - Exit to DONE after the iteration with cnt == N-1, i.e. exactly N RUN cycles.
- DONE, exactly one cycle:
  - done = 1; result = acc; we = (wa != 31); next state IDLE.
  - Register 31 is the hardwired zero: a multiply targeting it completes normally but asserts no write.
- Latency:
  - Start accepted at edge k; done is high in the cycle after edge k+N.
  - Total N+1 cycles start-to-done.
  - Next start is accepted no earlier than the IDLE cycle after DONE.
- result holding:
  - result keeps its value after DONE until the next reset.
  - result is not cleared by a new start; it updates only on entry to DONE.
  - wa updates on an accepted start.
- Boundary conditions:
  - start while busy (RUN or DONE): ignored; no effect on operands or latency.
  - a or b = 0: full N-cycle run; result = 0.
  - Overflow: upper N bits of the 2N-bit product are discarded, e.g. (2^N-1)*2 = 2^N-2.
  - reset mid-RUN or in DONE: next cycle is IDLE with all reset values; no done and no we pulse.
  - reset and start in the same cycle: reset wins.
- Operands are unsigned.
  - The low N bits equal the two's-complement signed product low bits, so signed MUL needs no extra logic.

Optional Feature:
- Macro: ITER_MUL_EARLY_TERM_EN
- Defined:
  - RUN also exits to DONE after any iteration whose post-shift mplier == 0.
  - RUN cycles = max(1, index of highest set bit of b + 1).
  - b = 0 gives 1 RUN cycle; b = 5 gives 3 RUN cycles.
  - Result identical to the undefined build.
- Undefined: RUN is always exactly N cycles, regardless of operands.

Test Plan:
1. Reset held 2 cycles, then idle 5 cycles -> busy=0, done=0, we=0, result=0, wa=0 throughout.
2. a=3, b=5, dest=9, start pulsed once -> busy for 65 cycles (N=64); done=1 for one cycle with result=15, wa=9, we=1. With the early-termination macro: done at start+4 cycles, same values.
3. a=0xFFFF_FFFF_FFFF_FFFF, b=2, dest=4 -> result=0xFFFF_FFFF_FFFF_FFFE, we=1, wa=4.
4. Start with a=7, b=6, dest=2; at RUN cycle 10 pulse start with a=1, b=1, dest=3 -> second request ignored; result=42, wa=2; only one done pulse.
5. a=10, b=10, dest=31 -> done=1, result=100, wa=31, we=0.
6. Start a=9, b=9; assert reset at RUN cycle 10 for 1 cycle -> next cycle busy=0; no done/we pulse for 70 cycles; result stays 0.
